// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter helpers and index hash for the branch predictor tables
package bp_pkg;

    localparam int CNT_W_DEF = 2;

    function automatic int unsigned weak_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
        return (v == ((32'd1 << w) - 32'd1)) ? v : v + 32'd1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

    // Word-aligned PC folded with a history value; callers truncate to their index width.
    function automatic logic [31:0] hash_idx(input logic [31:0] pc, input logic [31:0] hist);
        return (pc >> 2) ^ hist;
    endfunction

endpackage

// File: rtl/tournament_predictor_p_if.sv
// rtl/tournament_predictor_p_if.sv - pipeline-side signals of the tournament predictor
interface tournament_predictor_p_if;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] pc_f;
    logic [31:0] pc_m;
    logic        branch_d;
    logic        branch_m;
    logic        actual_take_m;
    logic        predict_wrong_m;
    logic        predict_f;
    logic        predict_d;

    modport master (
        output stall_d, flush_d, pc_f, pc_m, branch_d, branch_m, actual_take_m, predict_wrong_m,
        input  predict_f, predict_d
    );

    modport slave (
        input  stall_d, flush_d, pc_f, pc_m, branch_d, branch_m, actual_take_m, predict_wrong_m,
        output predict_f, predict_d
    );
endinterface

// File: rtl/bp_counter_bank.sv
// rtl/bp_counter_bank.sv - bank of saturating counters: comb lookup port plus read/write update port
module bp_counter_bank
    import bp_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic [IDX_W-1:0] upd_idx_i,
    output logic [CNT_W-1:0] upd_cnt_o,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_cnt_i
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] INIT = CNT_W'(weak_init(CNT_W));

    logic [CNT_W-1:0] cnt_q [DEPTH];

    // Both reads see the pre-write contents, so a same-cycle lookup gets the old value.
    assign rd_cnt_o  = cnt_q[rd_idx_i];
    assign upd_cnt_o = cnt_q[upd_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= INIT;
        end else if (wr_en_i) begin
            cnt_q[upd_idx_i] <= wr_cnt_i;
        end
    end
endmodule

// File: rtl/tournament_predictor_p.sv
// rtl/tournament_predictor_p.sv - tournament (local + gshare) predictor with speculative, repairable GHR
module tournament_predictor_p
    import bp_pkg::*;
#(
    parameter int GHR_W      = 8,
    parameter int LHT_IDX_W  = 6,
    parameter int LH_W       = 6,
    parameter int CPHT_IDX_W = 8,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic                    clk,
    input logic                    rst,
    tournament_predictor_p_if.slave bp
);
    localparam int LHT_DEPTH = 1 << LHT_IDX_W;

    logic [LH_W-1:0]       lht_q [LHT_DEPTH];
    logic [GHR_W-1:0]      spec_ghr_q, spec_ghr_d;
    logic [GHR_W-1:0]      commit_ghr_q, commit_ghr_d;
    logic                  predict_d_q, predict_d_d;

    logic [LHT_IDX_W-1:0]  l_idx_f, l_idx_m;
    logic [LH_W-1:0]       lh_f, lh_m;
    logic [GHR_W-1:0]      g_idx_f, g_idx_m;
    logic [CPHT_IDX_W-1:0] c_idx_f, c_idx_m;
    logic [CNT_W-1:0]      l_cnt_f, l_cnt_m, g_cnt_f, g_cnt_m, c_cnt_f, c_cnt_m;
    logic [CNT_W-1:0]      l_wr, g_wr, c_wr;
    logic                  lp_m, gp_m, c_we;

    always_comb begin
        l_idx_f = LHT_IDX_W'(hash_idx(bp.pc_f, 32'd0));
        l_idx_m = LHT_IDX_W'(hash_idx(bp.pc_m, 32'd0));
        g_idx_f = GHR_W'(hash_idx(bp.pc_f, 32'(spec_ghr_q)));
        g_idx_m = GHR_W'(hash_idx(bp.pc_m, 32'(commit_ghr_q)));
        c_idx_f = CPHT_IDX_W'(hash_idx(bp.pc_f, 32'd0));
        c_idx_m = CPHT_IDX_W'(hash_idx(bp.pc_m, 32'd0));
    end

    assign lh_f = lht_q[l_idx_f];
    assign lh_m = lht_q[l_idx_m];

    bp_counter_bank #(.IDX_W(LH_W), .CNT_W(CNT_W)) u_local_pht (
        .clk(clk), .rst_n(rst), .rd_idx_i(lh_f), .rd_cnt_o(l_cnt_f),
        .upd_idx_i(lh_m), .upd_cnt_o(l_cnt_m), .wr_en_i(bp.branch_m), .wr_cnt_i(l_wr)
    );

    bp_counter_bank #(.IDX_W(GHR_W), .CNT_W(CNT_W)) u_global_pht (
        .clk(clk), .rst_n(rst), .rd_idx_i(g_idx_f), .rd_cnt_o(g_cnt_f),
        .upd_idx_i(g_idx_m), .upd_cnt_o(g_cnt_m), .wr_en_i(bp.branch_m), .wr_cnt_i(g_wr)
    );

    bp_counter_bank #(.IDX_W(CPHT_IDX_W), .CNT_W(CNT_W)) u_choice (
        .clk(clk), .rst_n(rst), .rd_idx_i(c_idx_f), .rd_cnt_o(c_cnt_f),
        .upd_idx_i(c_idx_m), .upd_cnt_o(c_cnt_m), .wr_en_i(c_we), .wr_cnt_i(c_wr)
    );

    assign bp.predict_f = c_cnt_f[CNT_W-1] ? g_cnt_f[CNT_W-1] : l_cnt_f[CNT_W-1];
    assign bp.predict_d = predict_d_q;

    // M-stage re-read uses commit_ghr so wrong-path speculation never trains the tables.
    always_comb begin
        lp_m = l_cnt_m[CNT_W-1];
        gp_m = g_cnt_m[CNT_W-1];
        l_wr = CNT_W'(bp.actual_take_m ? sat_inc(32'(l_cnt_m), CNT_W) : sat_dec(32'(l_cnt_m)));
        g_wr = CNT_W'(bp.actual_take_m ? sat_inc(32'(g_cnt_m), CNT_W) : sat_dec(32'(g_cnt_m)));
        c_wr = CNT_W'((gp_m == bp.actual_take_m) ? sat_inc(32'(c_cnt_m), CNT_W) : sat_dec(32'(c_cnt_m)));
        c_we = bp.branch_m & (lp_m ^ gp_m);
    end

    always_comb begin
        predict_d_d  = predict_d_q;
        spec_ghr_d   = spec_ghr_q;
        commit_ghr_d = commit_ghr_q;
        if (bp.flush_d)       predict_d_d = 1'b0;
        else if (!bp.stall_d) predict_d_d = bp.predict_f;
        if (bp.branch_d && !bp.stall_d && !bp.flush_d)
            spec_ghr_d = {spec_ghr_q[GHR_W-2:0], predict_d_q};
        if (bp.branch_m) begin
            commit_ghr_d = {commit_ghr_q[GHR_W-2:0], bp.actual_take_m};
            if (bp.predict_wrong_m) spec_ghr_d = {commit_ghr_q[GHR_W-2:0], bp.actual_take_m};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predict_d_q  <= 1'b0;
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            predict_d_q  <= predict_d_d;
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LHT_DEPTH; i++) lht_q[i] <= '0;
        end else if (bp.branch_m) begin
            lht_q[l_idx_m] <= {lh_m[LH_W-2:0], bp.actual_take_m};
        end
    end
endmodule

// File: tb/tb_tournament_predictor_p.sv
// tb/tb_tournament_predictor_p.sv - randomized and directed checks against a table-level reference model
module tb_tournament_predictor_p;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tournament_predictor_p_if bp ();
    tournament_predictor_p dut (.clk(clk), .rst(rst), .bp(bp.slave));

    int passed = 0;
    int total  = 0;

    // reference state: plain integer tables, counters 0..3, taken when >= 2
    int lpht [64];
    int gpht [256];
    int ch   [256];
    int lht  [64];
    int sghr, cghr, pd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin lpht[i] = 1; lht[i] = 0; end
        for (int i = 0; i < 256; i++) begin gpht[i] = 1; ch[i] = 1; end
        sghr = 0; cghr = 0; pd = 0;
    endtask

    function automatic int model_pf(input int unsigned pc);
        int unsigned w;
        int lp, gp;
        w  = pc >> 2;
        lp = (lpht[lht[w % 64]] >= 2) ? 1 : 0;
        gp = (gpht[(w ^ sghr) % 256] >= 2) ? 1 : 0;
        return (ch[w % 256] >= 2) ? gp : lp;
    endfunction

    function automatic int toward(input int v, input int up);
        return up != 0 ? ((v < 3) ? v + 1 : 3) : ((v > 0) ? v - 1 : 0);
    endfunction

    task automatic cycle(input int stall, input int flush, input int unsigned pcf, input int unsigned pcm,
                         input int bd, input int bm, input int act, input int pw, input string tag);
        int pf, pd_new, sg_new, li, lh, gi, ci, lpm, gpm;
        int unsigned wm;
        bp.stall_d = stall[0]; bp.flush_d = flush[0]; bp.pc_f = pcf; bp.pc_m = pcm;
        bp.branch_d = bd[0]; bp.branch_m = bm[0]; bp.actual_take_m = act[0]; bp.predict_wrong_m = pw[0];
        #1;
        pf = model_pf(pcf);
        check({tag, ".predict_f"}, 32'(bp.predict_f), 32'(pf));
        pd_new = flush != 0 ? 0 : (stall != 0 ? pd : pf);
        sg_new = sghr;
        if (bd != 0 && stall == 0 && flush == 0) sg_new = ((sghr << 1) | pd) & 255;
        if (bm != 0) begin
            if (pw != 0) sg_new = ((cghr << 1) | act) & 255;
            wm  = pcm >> 2;
            li  = int'(wm % 64);
            lh  = lht[li];
            gi  = int'((wm ^ cghr) % 256);
            ci  = int'(wm % 256);
            lpm = (lpht[lh] >= 2) ? 1 : 0;
            gpm = (gpht[gi] >= 2) ? 1 : 0;
            lpht[lh] = toward(lpht[lh], act);
            gpht[gi] = toward(gpht[gi], act);
            if (lpm != gpm) ch[ci] = toward(ch[ci], (gpm == act) ? 1 : 0);
            lht[li] = ((lh << 1) | act) & 63;
            cghr    = ((cghr << 1) | act) & 255;
        end
        pd = pd_new; sghr = sg_new;
        @(posedge clk);
        #1;
        check({tag, ".predict_d"}, 32'(bp.predict_d), 32'(pd));
        check({tag, ".spec_ghr"}, 32'(dut.spec_ghr_q), 32'(sghr));
        check({tag, ".commit_ghr"}, 32'(dut.commit_ghr_q), 32'(cghr));
    endtask

    int unsigned pcs [6];

    initial begin
        pcs[0] = 32'h1000; pcs[1] = 32'h1004; pcs[2] = 32'h2000;
        pcs[3] = 32'hBFC00010; pcs[4] = 32'h2400; pcs[5] = 32'h1010;
        bp.stall_d = 0; bp.flush_d = 0; bp.pc_f = 32'h1000; bp.pc_m = 0;
        bp.branch_d = 0; bp.branch_m = 0; bp.actual_take_m = 0; bp.predict_wrong_m = 0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.predict_d", 32'(bp.predict_d), 32'd0);
        check("reset.predict_f", 32'(bp.predict_f), 32'd0);
        rst = 1'b1;

        // reset lookup then one unstalled cycle
        cycle(0, 0, 32'h1000, 0, 0, 0, 0, 0, "t1");

        // repeated taken training at one PC
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'hBFC00010, 32'hBFC00010, 0, 1, 1, 0, "t2");
        cycle(0, 0, 32'hBFC00010, 0, 0, 0, 0, 0, "t2.look");

        // alternating pattern at one PC
        for (int i = 0; i < 16; i++) cycle(0, 0, 32'h2000, 32'h2000, 0, 1, i % 2, 0, "t3");
        cycle(0, 0, 32'h2000, 0, 0, 0, 0, 0, "t3.look");

        // speculative history corruption then repair
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'hBFC00010, 0, 1, 0, 0, 0, "t4.spec");
        cycle(0, 0, 32'h1000, 32'hBFC00010, 1, 1, 0, 1, "t4.repair");

        // flush over stall, then stall holds
        cycle(0, 0, 32'hBFC00010, 0, 0, 0, 0, 0, "t5.load");
        cycle(1, 1, 32'hBFC00010, 0, 1, 0, 0, 0, "t5.flush");
        cycle(0, 0, 32'hBFC00010, 0, 0, 0, 0, 0, "t5.reload");
        for (int i = 0; i < 3; i++) cycle(1, 0, 32'h1000, 0, 1, 0, 0, 0, "t5.stall");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
                  pcs[$urandom_range(0, 5)], pcs[$urandom_range(0, 5)],
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), "rand");
        end

        // asynchronous reset in the middle of an update
        bp.pc_f = 32'h2000; bp.pc_m = 32'h2000; bp.branch_m = 1; bp.actual_take_m = 1;
        bp.predict_wrong_m = 1; bp.branch_d = 1; bp.stall_d = 0; bp.flush_d = 0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("t6.predict_f", 32'(bp.predict_f), 32'(model_pf(32'h2000)));
        check("t6.predict_d", 32'(bp.predict_d), 32'd0);
        check("t6.spec_ghr", 32'(dut.spec_ghr_q), 32'd0);
        check("t6.commit_ghr", 32'(dut.commit_ghr_q), 32'd0);
        check("t6.lht", 32'(dut.lht_q[0]), 32'd0);
        @(posedge clk);
        #1;
        check("t6.hold_commit", 32'(dut.commit_ghr_q), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, pcs[$urandom_range(0, 5)], pcs[$urandom_range(0, 5)], 1,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, "t6.post");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
